ov5640_line_packer: RTL and testbench
=====================================

// Module: ov5640_line_packer
// PURPOSE
//  Downstream of the OV5640 16-bit pixel assembler, in the ov5640_pclk domain.
//  Takes valid RGB565 pixels, frames them using vsync, counts pixels and lines, and packs pixel pairs into 32-bit words.
//  Writes the words into the write side of the pclk->eth async FIFO.
//  Drops the rest of a line on FIFO overflow and reports line-done and error events to the UDP packet scheduler.
// PARAMETERS
//  H_PIXEL  640  pixels per line; must be even
//  V_LINE   480  lines per frame
// PORTS
//  ov5640_pclk    in   1   clock, camera pixel clock
//  sys_rst_n      in   1   asynchronous reset, active-low
//  ov5640_vsync   in   1   camera frame sync; a rising edge starts a frame
//  pix_en         in   1   pixel valid, single-cycle strobe
//  pix_data       in   16  RGB565 pixel, sampled when pix_en=1
//  fifo_full      in   1   async FIFO full flag, pclk domain
//  fifo_wr_en     out  1   FIFO write strobe
//  fifo_wr_data   out  32  packed word {pixel0, pixel1}
//  frame_start    out  1   1-cycle pulse on a frame start
//  line_done      out  1   1-cycle pulse when the last pixel of a line is consumed
//  line_num       out  11  index of the last completed line, 0-based; holds its value
//  line_err       out  1   1-cycle pulse when a line is truncated by fifo_full
//  frame_err      out  1   1-cycle pulse when vsync arrives with 0 < lines < V_LINE
// BEHAVIOUR
//  Reset values: every output 0; state IDLE; all counters 0.
//  Frame start: vsync_dly registered; edge = vsync & ~vsync_dly.
//   - frame_start pulses in the cycle after the edge is seen.
//   - On the edge, from any state: go to ACTIVE; pix_cnt=0, line_cnt=0, half=0.
//   - pix_en in the same cycle as the edge is ignored.
//   - frame_err pulses with frame_start if 0 < line_cnt < V_LINE at the edge.
//  States:
//   - IDLE: ignore pix_en; wait for a vsync edge.
//   - ACTIVE: accept pixels.
//     - half=0: latch pix_data into hi_reg.
//     - half=1: fifo_wr_en=1 next cycle, fifo_wr_data={hi_reg,pix_data}. Write latency is 1 cycle.
//     - If fifo_full=1 on a cycle that would write (data word or header): suppress that write, line_err pulses next cycle, go to DROP.
//   - DROP: count pixels but write nothing; return to ACTIVE at line end.
//   - DONE: entered when line_cnt reaches V_LINE; ignore pix_en until the next vsync edge.
//  pix_cnt counts every accepted pix_en in ACTIVE and DROP.
//  Line end, when pix_cnt = H_PIXEL-1 with pix_en:
//   - pix_cnt -> 0, half -> 0.
//   - line_done pulses next cycle, aligned with the final write.
//   - line_num <= line_cnt; line_cnt increments.
//   - The line is counted even if it was dropped.
//  line_cnt = V_LINE-1 at line end: go to DONE, not ACTIVE.
//  Simultaneous events:
//   - A vsync edge overrides a line end in the same cycle: no line_done; counters clear.
//   - A fifo_full change mid-line has no effect until the next write attempt.
//  fifo_full while fifo_wr_en=0 is irrelevant; the block never stalls its input.
// CONFIGURATION
//  OV5640_PACK_HDR_EN defined:
//   - On the first pixel of each line (pix_cnt=0, ACTIVE), write header {16'hA55A, 5'd0, line_cnt[10:0]} next cycle.
//   - This cycle never collides with a data write, which only occurs when half=1.
//   - If fifo_full=1 then: no header, line_err pulses, DROP.
//   - Words per line = H_PIXEL/2 + 1.
//  OV5640_PACK_HDR_EN undefined: no header; words per line = H_PIXEL/2.
// TESTING
//  The bench uses H_PIXEL=4, V_LINE=2.
//  Basic frame: vsync edge, then 8 pixels 16'h0001..16'h0008, fifo_full=0.
//   -> frame_start once; words 32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008.
//   -> line_done twice, with line_num 0 then 1; state DONE.
//  Overflow: fifo_full=1 for the 2nd word of line 0.
//   -> 1 word written for line 0; line_err once.
//   -> Line 1 writes 2 words normally; line_done x2.
//  Short frame: 1 complete line, then a vsync edge.
//   -> frame_err and frame_start in the same cycle; counters reset.
//   -> The next line reports line_num 0.
//  Pixels after DONE or before the first vsync: 6 pix_en pulses -> no fifo_wr_en, no line_done.
//  Reset mid-line: assert sys_rst_n=0 after 3 pixels.
//   -> All outputs 0 immediately; no writes until the next vsync edge.
//  OV5640_PACK_HDR_EN: basic frame -> line 0 begins with 32'hA55A0000, line 1 with 32'hA55A0001; 6 words total.

Source files
------------

// File: rtl/ov5640_line_packer_if.sv
// ----------------------------------------------------------------------------
// ov5640_line_packer_if
//
// Purpose:
//   Write side of the pclk->eth async FIFO. The line packer pushes 32-bit
//   words through this bundle. The FIFO reports back its full flag, which is
//   already in the pclk domain.
//
// Signals:
//   fifo_full     FIFO full flag (FIFO -> packer)
//   fifo_wr_en    single-cycle write strobe (packer -> FIFO)
//   fifo_wr_data  packed word {pixel0, pixel1} or line header (packer -> FIFO)
//
// Modports:
//   master  the line packer (drives write strobe and data)
//   slave   the FIFO write port (drives the full flag)
// ----------------------------------------------------------------------------
interface ov5640_line_packer_if;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;

    modport master (
        input  fifo_full,
        output fifo_wr_en,
        output fifo_wr_data
    );

    modport slave (
        output fifo_full,
        input  fifo_wr_en,
        input  fifo_wr_data
    );
endinterface

// File: rtl/ov5640_line_packer.sv
// ----------------------------------------------------------------------------
// ov5640_line_packer
//
// Purpose:
//   Sits after the OV5640 16-bit pixel assembler in the ov5640_pclk domain.
//   Frames the RGB565 pixel stream on vsync rising edges. Counts pixels and
//   lines. Packs pixel pairs into 32-bit words {pixel0, pixel1}, which are
//   written into the pclk->eth async FIFO. When the FIFO is full on a write
//   attempt, the rest of that line is dropped. Line-done and error events
//   are reported to the UDP packet scheduler as single-cycle pulses.
//
// Parameters:
//   H_PIXEL  pixels per line (must be even)
//   V_LINE   lines per frame (at most 2047)
//
// Ports:
//   ov5640_pclk   in   camera pixel clock
//   sys_rst_n     in   asynchronous reset, active-low
//   ov5640_vsync  in   camera frame sync, a rising edge starts a frame
//   pix_en        in   pixel valid strobe
//   pix_data      in   RGB565 pixel, sampled when pix_en is high
//   fifo          --   FIFO write bundle (master side: full in, wr_en/data out)
//   frame_start   out  1-cycle pulse after a vsync rising edge
//   line_done     out  1-cycle pulse with the final word of a line
//   line_num      out  index of the last completed line (held)
//   line_err      out  1-cycle pulse when a line gets truncated by FIFO full
//   frame_err     out  1-cycle pulse when a frame restarts part-way through
//
// Build option:
//   OV5640_PACK_HDR_EN  when defined, each line is prefixed with a header
//                       word {16'hA55A, 5'd0, line_cnt}. The FIFO then
//                       receives H_PIXEL/2 + 1 words per line instead of
//                       H_PIXEL/2.
// ----------------------------------------------------------------------------
module ov5640_line_packer #(
    parameter int H_PIXEL = 640,
    parameter int V_LINE  = 480
) (
    input  logic                    ov5640_pclk,
    input  logic                    sys_rst_n,
    input  logic                    ov5640_vsync,
    input  logic                    pix_en,
    input  logic [15:0]             pix_data,
    ov5640_line_packer_if.master    fifo,
    output logic                    frame_start,
    output logic                    line_done,
    output logic [10:0]             line_num,
    output logic                    line_err,
    output logic                    frame_err
);

    // Pixel counter width. It is kept at least one bit wide so that tiny
    // test configurations still elaborate.
    localparam int PW = (H_PIXEL > 2) ? $clog2(H_PIXEL) : 1;

    localparam logic [PW-1:0] H_LAST     = PW'(H_PIXEL - 1);
    localparam logic [10:0]   V_LINE_W   = 11'(V_LINE);
    localparam logic [10:0]   V_LAST     = 11'(V_LINE - 1);

`ifdef OV5640_PACK_HDR_EN
    localparam logic [15:0]   HDR_TAG    = 16'hA55A;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]    state;
    logic          vsync_dly;
    logic [PW-1:0] pix_cnt;
    logic [10:0]   line_cnt;
    logic          half;
    logic [15:0]   hi_reg;

    logic          vsync_edge;
    logic          accept;
    logic          line_end;
    logic          data_try;
    logic          hdr_try;
    logic          wr_attempt;
    logic          overflow;
    logic          frame_short;
    logic [31:0]   hdr_word;

    // Decode the current cycle. A vsync edge takes priority over pixel
    // acceptance, so a pixel that arrives with the edge is ignored. A line
    // end on that same cycle is then lost as well, because the counters are
    // cleared anyway. The full flag only matters on cycles that would write.
    // That is why the block never stalls its input.
    always_comb begin
        vsync_edge  = ov5640_vsync & ~vsync_dly;
        accept      = pix_en & ~vsync_edge &
                      ((state == ST_ACTIVE) || (state == ST_DROP));
        line_end    = accept && (pix_cnt == H_LAST);
        data_try    = accept && (state == ST_ACTIVE) && half;
`ifdef OV5640_PACK_HDR_EN
        // The header goes out on the first pixel of the line. That pixel
        // always has half == 0, so the header can never collide with a
        // data write.
        hdr_try     = accept && (state == ST_ACTIVE) && (pix_cnt == '0);
        hdr_word    = {HDR_TAG, 5'd0, line_cnt};
`else
        hdr_try     = 1'b0;
        hdr_word    = 32'd0;
`endif
        wr_attempt  = data_try | hdr_try;
        overflow    = wr_attempt & fifo.fifo_full;
        frame_short = (line_cnt != 11'd0) && (line_cnt < V_LINE_W);
    end

    // Main sequencer. The event outputs default low every cycle, so each one
    // is a single-cycle pulse. All outputs are registered, which gives one
    // cycle of latency from the pixel strobe to the FIFO write and to
    // line_done. line_done therefore lines up with the last word of the line.
    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state             <= ST_IDLE;
            vsync_dly         <= 1'b0;
            pix_cnt           <= '0;
            line_cnt          <= 11'd0;
            half              <= 1'b0;
            hi_reg            <= 16'd0;
            fifo.fifo_wr_en   <= 1'b0;
            fifo.fifo_wr_data <= 32'd0;
            frame_start       <= 1'b0;
            line_done         <= 1'b0;
            line_num          <= 11'd0;
            line_err          <= 1'b0;
            frame_err         <= 1'b0;
        end else begin
            vsync_dly       <= ov5640_vsync;
            fifo.fifo_wr_en <= 1'b0;
            frame_start     <= 1'b0;
            line_done       <= 1'b0;
            line_err        <= 1'b0;
            frame_err       <= 1'b0;

            if (vsync_edge) begin
                // A new frame starts here, whatever state we were in. If the
                // previous frame stopped after some lines but before the
                // full count, report it.
                state       <= ST_ACTIVE;
                pix_cnt     <= '0;
                line_cnt    <= 11'd0;
                half        <= 1'b0;
                frame_start <= 1'b1;
                frame_err   <= frame_short;
            end else if (accept) begin
                if ((state == ST_ACTIVE) && !half) begin
                    hi_reg <= pix_data;
                end
                half <= ~half;

                if (wr_attempt && !fifo.fifo_full) begin
                    fifo.fifo_wr_en   <= 1'b1;
                    fifo.fifo_wr_data <= hdr_try ? hdr_word
                                                 : {hi_reg, pix_data};
                end

                // A refused write truncates the line. Pixels are still
                // counted in DROP so that the line boundary is kept.
                if (overflow) begin
                    line_err <= 1'b1;
                    state    <= ST_DROP;
                end

                // At the line end, the next state set here overrides the DROP
                // set above. A refusal on the very last word has nothing left
                // to drop, so the packer returns straight to ACTIVE (or moves
                // to DONE).
                if (line_end) begin
                    pix_cnt   <= '0;
                    half      <= 1'b0;
                    line_done <= 1'b1;
                    line_num  <= line_cnt;
                    line_cnt  <= line_cnt + 11'd1;
                    state     <= (line_cnt == V_LAST) ? ST_DONE : ST_ACTIVE;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov5640_line_packer.sv
// ----------------------------------------------------------------------------
// tb_ov5640_line_packer
//
// Purpose:
//   Self-checking bench for ov5640_line_packer with H_PIXEL=4 and V_LINE=2.
//   Directed stimulus pushes the expected FIFO words and line_done records
//   into queues. A monitor on the falling clock edge pops those queues and
//   compares them against the DUT outputs. Event pulse counts are checked
//   at the end of each phase. Define OV5640_PACK_HDR_EN for both the RTL and
//   the bench to cover the line-header build.
// ----------------------------------------------------------------------------
module tb_ov5640_line_packer;

    logic        ov5640_pclk = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        ov5640_vsync = 1'b0;
    logic        pix_en      = 1'b0;
    logic [15:0] pix_data    = 16'd0;
    logic        frame_start;
    logic        line_done;
    logic [10:0] line_num;
    logic        line_err;
    logic        frame_err;

    ov5640_line_packer_if fifo_bus ();

    ov5640_line_packer #(
        .H_PIXEL (4),
        .V_LINE  (2)
    ) dut (
        .ov5640_pclk  (ov5640_pclk),
        .sys_rst_n    (sys_rst_n),
        .ov5640_vsync (ov5640_vsync),
        .pix_en       (pix_en),
        .pix_data     (pix_data),
        .fifo         (fifo_bus),
        .frame_start  (frame_start),
        .line_done    (line_done),
        .line_num     (line_num),
        .line_err     (line_err),
        .frame_err    (frame_err)
    );

    always #5 ov5640_pclk = ~ov5640_pclk;

    // Scoreboard state
    logic [31:0] exp_words[$];
    logic [10:0] exp_lines[$];
    logic        exp_line_wr[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          obs_fs = 0, obs_le = 0, obs_fe = 0;
    int          snap_fs, snap_le, snap_fe;
    logic [31:0] mon_word;
    logic [10:0] mon_line;
    logic        mon_wr;

    // Compares one value and reports a failure on a mismatch.
    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 32'h%h, expected 32'h%h", name, act, exp);
        end
    endtask

    // Records an output event that had no matching expectation.
    task automatic report_unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got 32'h%h, expected no event", name, act);
    endtask

    // Monitor: consumes expectations whenever the DUT presents a write or
    // a line_done, and tallies the other event pulses.
    always @(negedge ov5640_pclk) begin
        if (sys_rst_n) begin
            if (fifo_bus.fifo_wr_en) begin
                if (exp_words.size() == 0) begin
                    report_unexpected("unexpected_write", fifo_bus.fifo_wr_data);
                end else begin
                    mon_word = exp_words.pop_front();
                    check_output("write_data", fifo_bus.fifo_wr_data, mon_word);
                end
            end
            if (line_done) begin
                if (exp_lines.size() == 0) begin
                    report_unexpected("unexpected_line_done", 32'(line_num));
                end else begin
                    mon_line = exp_lines.pop_front();
                    mon_wr   = exp_line_wr.pop_front();
                    check_output("line_num", 32'(line_num), 32'(mon_line));
                    check_output("line_done_write_align",
                                 32'(fifo_bus.fifo_wr_en), 32'(mon_wr));
                end
            end
            if (frame_start) obs_fs++;
            if (line_err)    obs_le++;
            if (frame_err) begin
                obs_fe++;
                check_output("frame_err_with_frame_start", 32'(frame_start), 32'd1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ov5640_pclk);
            #1;
        end
    endtask

    // Drives one pixel strobe, optionally with the FIFO reporting full.
    task automatic apply_stimulus(input logic [15:0] d, input logic full);
        pix_en             = 1'b1;
        pix_data           = d;
        fifo_bus.fifo_full = full;
        @(posedge ov5640_pclk);
        #1;
        pix_en             = 1'b0;
        fifo_bus.fifo_full = 1'b0;
    endtask

    task automatic pulse_vsync();
        ov5640_vsync = 1'b1;
        idle(1);
        ov5640_vsync = 1'b0;
        idle(1);
    endtask

    task automatic send_pixels(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(first + 16'(i), 1'b0);
    endtask

    task automatic expect_header(input logic [10:0] ln);
`ifdef OV5640_PACK_HDR_EN
        exp_words.push_back({16'hA55A, 5'd0, ln});
`else
        if (ln > 11'd2047) exp_words.push_back(32'd0);
`endif
    endtask

    task automatic expect_line(input logic [10:0] ln, input logic wr);
        exp_lines.push_back(ln);
        exp_line_wr.push_back(wr);
    endtask

    task automatic start_phase();
        snap_fs = obs_fs;
        snap_le = obs_le;
        snap_fe = obs_fe;
    endtask

    // Lets the pipeline drain, then checks that every expectation was
    // consumed and that the event pulse counts match.
    task automatic check_phase(input string name, input int fs, input int le,
                               input int fe);
        idle(3);
        check_output({name, "_words_left"}, 32'(exp_words.size()), 32'd0);
        check_output({name, "_lines_left"}, 32'(exp_lines.size()), 32'd0);
        check_output({name, "_frame_start_cnt"}, 32'(obs_fs - snap_fs), 32'(fs));
        check_output({name, "_line_err_cnt"}, 32'(obs_le - snap_le), 32'(le));
        check_output({name, "_frame_err_cnt"}, 32'(obs_fe - snap_fe), 32'(fe));
        exp_words.delete();
        exp_lines.delete();
        exp_line_wr.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check_output({name, "_wr_en"}, 32'(fifo_bus.fifo_wr_en), 32'd0);
        check_output({name, "_wr_data"}, fifo_bus.fifo_wr_data, 32'd0);
        check_output({name, "_frame_start"}, 32'(frame_start), 32'd0);
        check_output({name, "_line_done"}, 32'(line_done), 32'd0);
        check_output({name, "_line_num"}, 32'(line_num), 32'd0);
        check_output({name, "_line_err"}, 32'(line_err), 32'd0);
        check_output({name, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        fifo_bus.fifo_full = 1'b0;
        #1;
        check_outputs_zero("reset");
        idle(2);
        sys_rst_n = 1'b1;
        idle(2);

        $display("[TB] pixels before first vsync");
        start_phase();
        send_pixels(16'h0001, 6);
        check_phase("pre_vsync", 0, 0, 0);

        $display("[TB] basic frame");
        start_phase();
        pulse_vsync();
        expect_header(11'd0);
        exp_words.push_back(32'h00010002);
        exp_words.push_back(32'h00030004);
        expect_line(11'd0, 1'b1);
        expect_header(11'd1);
        exp_words.push_back(32'h00050006);
        exp_words.push_back(32'h00070008);
        expect_line(11'd1, 1'b1);
        send_pixels(16'h0001, 8);
        check_phase("basic", 1, 0, 0);

        $display("[TB] pixels after DONE");
        start_phase();
        send_pixels(16'h0101, 6);
        check_phase("after_done", 0, 0, 0);

        $display("[TB] reset mid-line");
        start_phase();
        pulse_vsync();
        expect_header(11'd0);
        exp_words.push_back(32'h00110012);
        send_pixels(16'h0011, 3);
        sys_rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        idle(2);
        sys_rst_n = 1'b1;
        idle(1);
        check_phase("reset_mid", 1, 0, 0);
        start_phase();
        send_pixels(16'h0201, 6);
        check_phase("after_reset", 0, 0, 0);

        $display("[TB] overflow");
        start_phase();
        pulse_vsync();
        expect_header(11'd0);
        exp_words.push_back(32'h00010002);
        expect_line(11'd0, 1'b0);
        expect_header(11'd1);
        exp_words.push_back(32'h00050006);
        exp_words.push_back(32'h00070008);
        expect_line(11'd1, 1'b1);
        apply_stimulus(16'h0001, 1'b0);
        apply_stimulus(16'h0002, 1'b0);
        apply_stimulus(16'h0003, 1'b0);
        apply_stimulus(16'h0004, 1'b1);
        apply_stimulus(16'h0005, 1'b0);
        apply_stimulus(16'h0006, 1'b0);
        apply_stimulus(16'h0007, 1'b1);
        apply_stimulus(16'h0008, 1'b0);
        check_phase("overflow", 1, 1, 0);

        $display("[TB] short frame");
        start_phase();
        pulse_vsync();
        expect_header(11'd0);
        exp_words.push_back(32'h00210022);
        exp_words.push_back(32'h00230024);
        expect_line(11'd0, 1'b1);
        send_pixels(16'h0021, 4);
        check_phase("short_line0", 1, 0, 0);
        start_phase();
        pulse_vsync();
        expect_header(11'd0);
        exp_words.push_back(32'h00310032);
        exp_words.push_back(32'h00330034);
        expect_line(11'd0, 1'b1);
        send_pixels(16'h0031, 4);
        check_phase("short_restart", 1, 0, 1);

        $display("[TB] vsync on a line end");
        start_phase();
        expect_header(11'd1);
        exp_words.push_back(32'h00410042);
        send_pixels(16'h0041, 3);
        ov5640_vsync = 1'b1;
        pix_en       = 1'b1;
        pix_data     = 16'h0044;
        idle(1);
        ov5640_vsync = 1'b0;
        pix_en       = 1'b0;
        idle(1);
        expect_header(11'd0);
        exp_words.push_back(32'h00510052);
        exp_words.push_back(32'h00530054);
        expect_line(11'd0, 1'b1);
        send_pixels(16'h0051, 4);
        check_phase("vsync_override", 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
